// File: rtl/leiwand_rv32_timer_pkg.sv
// Shared types and constants for the leiwand_rv32 machine timer.
// Register word indices and CTRL bit positions match the SoC decode and firmware view.
package leiwand_rv32_timer_pkg;

  localparam int unsigned TIMER_ADDR_W = 3;
  localparam int unsigned TIMER_WORD_W = 32;
  localparam int unsigned TIMER_TIME_W = 64;

  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_IE_BIT = 1;

  typedef enum logic [TIMER_ADDR_W-1:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_STATUS      = 3'd5,
    REG_RSVD6       = 3'd6,
    REG_RSVD7       = 3'd7
  } timer_reg_e;

  typedef struct packed {
    logic ie;
    logic en;
  } timer_ctrl_t;

  // CTRL as seen on the bus: EN in bit 0, IE in bit 1, everything else zero.
  function automatic logic [TIMER_WORD_W-1:0] ctrl_word(input timer_ctrl_t c);
    logic [TIMER_WORD_W-1:0] w;
    w              = '0;
    w[CTRL_EN_BIT] = c.en;
    w[CTRL_IE_BIT] = c.ie;
    return w;
  endfunction

endpackage

// File: rtl/leiwand_rv32_prescaler.sv
// Free-running tick generator: one tick every CLK_DIV enabled clk cycles.
// Disabling holds the counter at zero so the next enable starts a full period.
module leiwand_rv32_prescaler #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned LAST  = (CLK_DIV > 0) ? CLK_DIV - 1 : 0;
  localparam int unsigned CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             at_last;

  assign at_last = (count == CNT_W'(LAST));
  assign tick    = enable && at_last;

  always_comb begin
    count_next = count + CNT_W'(1);
    if (!enable || at_last) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/leiwand_rv32_timer.sv
// RISC-V style machine timer as a pipelined Wishbone responder with a level interrupt.
// Define LEIWAND_RV32_TIMER_SHADOW_EN to latch mtime[63:32] on MTIME_LO reads for torn-free 64-bit reads.
module leiwand_rv32_timer
  import leiwand_rv32_timer_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned CLK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TIMER_ADDR_W-1:0] wb_addr,
  input  logic [MEM_WIDTH-1:0]    wb_data_in,
  output logic [MEM_WIDTH-1:0]    wb_data_out,
  input  logic                    wb_we,
  input  logic                    wb_stb,
  output logic                    wb_ack,
  input  logic                    wb_cyc,
  output logic                    wb_stall,
  output logic                    timer_irq
);

  logic [TIMER_TIME_W-1:0] mtime;
  logic [TIMER_TIME_W-1:0] mtime_next;
  logic [TIMER_TIME_W-1:0] mtimecmp;
  logic [TIMER_TIME_W-1:0] mtimecmp_next;
  timer_ctrl_t             ctrl;
  timer_ctrl_t             ctrl_next;

  logic                    accept_c;
  logic                    write_c;
  logic                    read_c;
  logic                    tick_c;
  logic                    match_c;
  timer_reg_e              idx_c;
  logic [TIMER_WORD_W-1:0] wdata_c;
  logic [TIMER_WORD_W-1:0] rdata_c;
  logic [TIMER_WORD_W-1:0] mtime_hi_view_c;

  assign accept_c = wb_cyc && wb_stb;
  assign write_c  = accept_c && wb_we;
  assign read_c   = accept_c && !wb_we;
  assign idx_c    = timer_reg_e'(wb_addr);
  assign wdata_c  = TIMER_WORD_W'(wb_data_in);
  assign match_c  = (mtime >= mtimecmp);
  assign wb_stall = 1'b0;

  leiwand_rv32_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (ctrl.en),
    .tick   (tick_c)
  );

`ifdef LEIWAND_RV32_TIMER_SHADOW_EN
  logic [TIMER_WORD_W-1:0] mtime_shadow;

  // Upper word snapshot taken with the pre-increment value when LO is read.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_shadow <= '0;
    end else if (read_c && (idx_c == REG_MTIME_LO)) begin
      mtime_shadow <= mtime[TIMER_TIME_W-1:TIMER_WORD_W];
    end
  end

  assign mtime_hi_view_c = mtime_shadow;
`else
  assign mtime_hi_view_c = mtime[TIMER_TIME_W-1:TIMER_WORD_W];
`endif

  // Read mux sees the registers as they stand before this edge's updates.
  always_comb begin
    rdata_c = '0;
    case (idx_c)
      REG_MTIME_LO:    rdata_c = mtime[TIMER_WORD_W-1:0];
      REG_MTIME_HI:    rdata_c = mtime_hi_view_c;
      REG_MTIMECMP_LO: rdata_c = mtimecmp[TIMER_WORD_W-1:0];
      REG_MTIMECMP_HI: rdata_c = mtimecmp[TIMER_TIME_W-1:TIMER_WORD_W];
      REG_CTRL:        rdata_c = ctrl_word(ctrl);
      REG_STATUS:      rdata_c = TIMER_WORD_W'(match_c);
      default:         rdata_c = '0;
    endcase
  end

  // A bus write to one mtime half overrides that half only; the other keeps the tick result.
  always_comb begin
    mtime_next    = tick_c ? (mtime + TIMER_TIME_W'(1)) : mtime;
    mtimecmp_next = mtimecmp;
    ctrl_next     = ctrl;
    if (write_c) begin
      case (idx_c)
        REG_MTIME_LO:    mtime_next[TIMER_WORD_W-1:0]               = wdata_c;
        REG_MTIME_HI:    mtime_next[TIMER_TIME_W-1:TIMER_WORD_W]    = wdata_c;
        REG_MTIMECMP_LO: mtimecmp_next[TIMER_WORD_W-1:0]            = wdata_c;
        REG_MTIMECMP_HI: mtimecmp_next[TIMER_TIME_W-1:TIMER_WORD_W] = wdata_c;
        REG_CTRL: begin
          ctrl_next.en = wdata_c[CTRL_EN_BIT];
          ctrl_next.ie = wdata_c[CTRL_IE_BIT];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      ctrl        <= '0;
      wb_ack      <= 1'b0;
      wb_data_out <= '0;
      timer_irq   <= 1'b0;
    end else begin
      mtime       <= mtime_next;
      mtimecmp    <= mtimecmp_next;
      ctrl        <= ctrl_next;
      wb_ack      <= accept_c;
      wb_data_out <= read_c ? MEM_WIDTH'(rdata_c) : '0;
      timer_irq   <= ctrl.ie && match_c;
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_timer.sv
// Scoreboard bench for leiwand_rv32_timer: two instances (CLK_DIV 1 and 4) share one bus.
// A cycle-level behavioural model predicts read data, acks and the interrupt level.
module tb_leiwand_rv32_timer;

  localparam int unsigned DIV0 = 1;
  localparam int unsigned DIV1 = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  wb_addr = '0;
  logic [31:0] wb_data_in = '0;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;

  logic [31:0] dout  [2];
  logic        ack   [2];
  logic        stall [2];
  logic        irq   [2];

  always #5 clk = ~clk;

  leiwand_rv32_timer #(.MEM_WIDTH(32), .CLK_DIV(DIV0)) u_dut0 (
    .clk(clk), .reset(reset), .wb_addr(wb_addr), .wb_data_in(wb_data_in),
    .wb_data_out(dout[0]), .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(ack[0]),
    .wb_cyc(wb_cyc), .wb_stall(stall[0]), .timer_irq(irq[0])
  );

  leiwand_rv32_timer #(.MEM_WIDTH(32), .CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .reset(reset), .wb_addr(wb_addr), .wb_data_in(wb_data_in),
    .wb_data_out(dout[1]), .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(ack[1]),
    .wb_cyc(wb_cyc), .wb_stall(stall[1]), .timer_irq(irq[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference state: mtime as a plain 64-bit number, a count of enabled cycles since the last tick.
  bit [63:0]   m_time   [2];
  bit [63:0]   m_cmp    [2];
  bit          m_en     [2];
  bit          m_ie     [2];
  int unsigned m_since  [2];
  bit [31:0]   m_shadow [2];
  bit          m_irq    [2];
  int unsigned m_div    [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int k, input logic [31:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  function automatic logic [31:0] qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic bit [31:0] model_read(input int k, input bit [2:0] a);
    case (a)
      3'd0: return m_time[k][31:0];
`ifdef LEIWAND_RV32_TIMER_SHADOW_EN
      3'd1: return m_shadow[k];
`else
      3'd1: return m_time[k][63:32];
`endif
      3'd2: return m_cmp[k][31:0];
      3'd3: return m_cmp[k][63:32];
      3'd4: return {30'd0, m_ie[k], m_en[k]};
      3'd5: return {31'd0, (m_time[k] >= m_cmp[k])};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit        acc;
    bit        tick;
    bit [63:0] nt;
    bit [31:0] rd;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_time[k] = 64'd0; m_cmp[k] = '1; m_en[k] = 1'b0; m_ie[k] = 1'b0;
        m_since[k] = 0; m_shadow[k] = 32'd0; m_irq[k] = 1'b0;
      end else begin
        acc  = wb_cyc && wb_stb;
        rd   = model_read(k, wb_addr);
        tick = 1'b0;
        if (m_en[k]) begin
          m_since[k]++;
          if (m_since[k] == m_div[k]) begin
            tick = 1'b1;
            m_since[k] = 0;
          end
        end else begin
          m_since[k] = 0;
        end
        m_irq[k] = m_ie[k] && (m_time[k] >= m_cmp[k]);
        nt = m_time[k] + 64'(tick);
        if (acc) begin
          qpush(k, wb_we ? 32'd0 : rd);
          if (!wb_we && wb_addr == 3'd0) m_shadow[k] = m_time[k][63:32];
          if (wb_we) begin
            case (wb_addr)
              3'd0: nt[31:0] = wb_data_in;
              3'd1: nt[63:32] = wb_data_in;
              3'd2: m_cmp[k][31:0] = wb_data_in;
              3'd3: m_cmp[k][63:32] = wb_data_in;
              3'd4: begin m_en[k] = wb_data_in[0]; m_ie[k] = wb_data_in[1]; end
              default: ;
            endcase
          end
        end
        m_time[k] = nt;
      end
    end
  endtask

  initial begin
    m_div[0] = DIV0;
    m_div[1] = DIV1;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: ack must appear exactly when the model has a response due.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ack[%0d]", k), 64'(ack[k]), 64'(qsize(k) != 0));
        if (ack[k] && qsize(k) != 0) begin
          e = qpop(k);
          check($sformatf("rdata[%0d]", k), 64'(dout[k]), 64'(e));
        end else if (!ack[k]) begin
          check($sformatf("idle_data[%0d]", k), 64'(dout[k]), 64'd0);
        end
        check($sformatf("stall[%0d]", k), 64'(stall[k]), 64'd0);
        check($sformatf("irq[%0d]", k), 64'(irq[k]), 64'(m_irq[k]));
      end
    end
  end

  task automatic bus(input bit we, input bit [2:0] a, input bit [31:0] d);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    end
  endtask

  initial begin
    int r;
    bit [2:0] a;
    bit [31:0] d;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) bus(1'b0, 3'(i), 32'd0);
    idle(2);

    bus(1'b1, 3'd4, 32'd1);
    idle(40);
    bus(1'b0, 3'd0, 32'd0);
    bus(1'b0, 3'd1, 32'd0);
    idle(1);

    bus(1'b1, 3'd4, 32'd0);
    bus(1'b1, 3'd0, 32'hFFFF_FFFE);
    bus(1'b1, 3'd1, 32'd0);
    bus(1'b1, 3'd4, 32'd1);
    idle(3);
    bus(1'b0, 3'd1, 32'd0);
    bus(1'b0, 3'd0, 32'd0);

    bus(1'b1, 3'd4, 32'd0);
    bus(1'b1, 3'd0, 32'd0);
    bus(1'b1, 3'd1, 32'd0);
    bus(1'b1, 3'd3, 32'd0);
    bus(1'b1, 3'd2, 32'd20);
    bus(1'b1, 3'd4, 32'd3);
    idle(30);
    bus(1'b0, 3'd5, 32'd0);
    bus(1'b1, 3'd2, 32'hFFFF_FFFF);
    idle(3);

    bus(1'b1, 3'd4, 32'd0);
    bus(1'b1, 3'd0, 32'hFFFF_FFFF);
    bus(1'b1, 3'd1, 32'd0);
    bus(1'b1, 3'd4, 32'd1);
    bus(1'b0, 3'd0, 32'd0);
    bus(1'b0, 3'd1, 32'd0);
    idle(2);

    bus(1'b1, 3'd6, 32'hDEAD_BEEF);
    bus(1'b0, 3'd4, 32'd0);
    bus(1'b0, 3'd7, 32'd0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (i == 200) begin
        @(negedge clk);
        reset = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 3'd4; wb_data_in = 32'd3;
        @(negedge clk);
        reset = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      end else if (r < 2) begin
        idle(1);
      end else if (r == 2) begin
        @(negedge clk);
        wb_cyc = $urandom_range(0, 1) == 1;
        wb_stb = !wb_cyc;
        wb_we = $urandom_range(0, 1) == 1;
        wb_addr = 3'($urandom_range(0, 7));
        wb_data_in = $urandom;
      end else begin
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        if (a <= 3'd3 && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if (a >= 3'd2 && a <= 3'd3 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 64));
        bus($urandom_range(0, 2) == 0, a, d);
      end
    end
    idle(4);

    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leiwand_rv32_timer.md
# leiwand_rv32_timer

Wishbone responder implementing a RISC-V style machine timer (64-bit `mtime`, 64-bit `mtimecmp`, control and status) for the leiwand_rv32 SoC. It sits on the core's shared wishbone bus next to the internal SRAM and ROM. It is selected by an SoC-level address-decoded strobe and drives a level timer interrupt toward the core. Its read data, ack and stall are OR-combined with the other slaves, so all three outputs must be zero whenever the timer is not responding.

## Interface
- `MEM_WIDTH`, default 32: data bus width; the register map assumes 32.
- `CLK_DIV`, default 1: clk cycles per `mtime` increment; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_addr` in 3: word index, which the SoC slices from byte address bits [4:2].
- `wb_data_in` in MEM_WIDTH: write data from the core.
- `wb_data_out` out MEM_WIDTH: read data; 0 except in ack cycles.
- `wb_we` in 1: write enable.
- `wb_stb` in 1: strobe, already qualified by the SoC address decode.
- `wb_ack` out 1: single-cycle acknowledge.
- `wb_cyc` in 1: bus cycle valid.
- `wb_stall` out 1: constant 0.
- `timer_irq` out 1: registered interrupt level.

## Operation
- Register map (word index):
  - 0 MTIME_LO.
  - 1 MTIME_HI.
  - 2 MTIMECMP_LO.
  - 3 MTIMECMP_HI.
  - 4 CTRL: bit0 EN, bit1 IE; other bits read 0.
  - 5 STATUS: bit0 MATCH = (mtime ≥ mtimecmp), unsigned 64-bit compare; read-only.
  - 6–7: read 0, writes ignored, still acked.
- Access is accepted when `wb_cyc && wb_stb` (stall is never asserted). Each accepted access is acked exactly once.
- Write: the addressed register updates at the accept edge.
- Read: data is captured at the accept edge and presented with ack.
- Prescaler:
  - Counter runs 0..CLK_DIV-1 while EN=1 and produces a tick when it equals CLK_DIV-1, then wraps to 0.
  - EN=0 holds the counter at 0.
  - CLK_DIV=1 ticks every enabled cycle.
- Increment: on a tick `mtime` += 1 as a full 64-bit value. LO 0xFFFFFFFF→0 carries into HI; all-ones wraps to 0.
- Simultaneous write and tick:
  - A write to MTIME_LO or MTIME_HI wins for the written half. The other half still takes the carry or increment computed from the pre-write value.
  - The prescaler is not reset by the write.
- `timer_irq` <= IE && MATCH, registered, so it lags the compare by one cycle. Writing `mtimecmp` above `mtime` deasserts it one cycle after the write edge.
- Reset values:
  - mtime 0.
  - mtimecmp 0xFFFFFFFF_FFFFFFFF.
  - CTRL 0; prescaler 0; HI shadow 0.
  - `wb_ack`, `wb_data_out`, `timer_irq` 0; `wb_stall` 0.
- Reset during an access: the pending ack is dropped and no write takes effect in the reset cycle.

## Timing
- Latency: ack is asserted on the cycle after the accept edge and stays high exactly 1 cycle.
- Back-to-back: strobes on consecutive cycles are each accepted and produce acks on consecutive cycles (pipelined, throughput 1/cycle).
- `wb_data_out` is valid only while `wb_ack`=1 and is 0 otherwise, including for writes.
- Read of MTIME_LO returns the value before any increment at the same edge.

## Configuration
- `LEIWAND_RV32_TIMER_SHADOW_EN` defined:
  - A read of MTIME_LO also latches `mtime[63:32]` into a shadow register.
  - A read of MTIME_HI returns the shadow, giving a torn-free 64-bit read of LO then HI.
- Not defined: there is no shadow, and MTIME_HI reads the live upper word.

## Structure
- Register word indices (`TIMER_REG_MTIME_LO`…`TIMER_REG_STATUS`) and CTRL bit positions go as `define`s in leiwand_rv32_constants.v, shared with the SoC decode and firmware headers.
- The SoC maps the timer at base 0x02004000 with a 32-byte window. It adds the timer's data, ack and stall terms to the existing OR-combines.
- One sub-module: `leiwand_rv32_prescaler` (parameter CLK_DIV; inputs clk, reset, enable; output tick).

## Test plan
- Reset, then read indices 0–5 → 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0; `timer_irq`=0; `wb_data_out`=0 between acks.
- CLK_DIV=4: write CTRL=1, wait 40 cycles, read MTIME_LO → 10 (±1 for the write/read edge alignment).
- Write MTIME_LO=0xFFFFFFFE and MTIME_HI=0, enable with CLK_DIV=1, wait 3 cycles → HI=1 and LO in 0x0..0x1, confirming the carry.
- Set mtimecmp=20 and CTRL=3 → `timer_irq` rises on the cycle after mtime reaches 20. Write MTIMECMP_LO=0xFFFFFFFF → irq falls 1 cycle later.
- With the SHADOW_EN macro: mtime HI=0 and LO=0xFFFFFFFF, read LO then HI across the carry → HI reads 0. Without the macro the same sequence reads HI=1.
- Issue 3 strobes on consecutive cycles (write, read, read to index 7) → 3 consecutive acks; index 7 read returns 0; stall stays 0.
